// File: rtl/merge_if.sv
// Bundled request/response buses around the N-to-1 merger: N master-side
// request/response slices plus the single slave-side pair.
interface merge_if #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int N_MASTERS = 2
);
  localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
  localparam int RESP_W = DATA_W + 1;

  // Request word {valid, addr, wdata, wstrb}, response word {rdata, ready}.
  // A requester holds valid and its payload stable until it sees ready=1;
  // the transfer completes in the cycle where valid and ready are both high.
  logic [N_MASTERS*REQ_W-1:0]  m_req;
  logic [N_MASTERS*RESP_W-1:0] m_resp;
  logic [REQ_W-1:0]            s_req;
  logic [RESP_W-1:0]           s_resp;

  // slave: the view of the merger itself, which serves the masters.
  modport slave  (input m_req, output m_resp, output s_req, input s_resp);
  modport master (output m_req, input m_resp, input s_req, output s_resp);
endinterface

// File: rtl/merge.sv
// Round-robin N-to-1 bus merger: one outstanding transaction at a time,
// grant held until the slave returns ready, priority rotates on completion.
module merge #(
  parameter int  DATA_W    = 32,
  parameter int  ADDR_W    = 32,
  parameter int  N_MASTERS = 2,
  localparam int SEL_W     = $clog2(N_MASTERS)
) (
  input  logic             clk,
  input  logic             rst_n,
  merge_if.slave           bus,
  output logic             dbg_state,
  output logic [SEL_W-1:0] dbg_sel,
  output logic [SEL_W-1:0] dbg_rr_ptr
);
  localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
  localparam int RESP_W = DATA_W + 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   sel, sel_nxt;
  logic [SEL_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [N_MASTERS-1:0] req_valid;
  logic               sel_valid;
  logic               slave_ready;
  logic               found;
  logic [SEL_W-1:0]   pick;
  int                 idx;

  always_comb begin
    req_valid = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      req_valid[i] = bus.m_req[i*REQ_W + REQ_W - 1];
    end
  end

  assign slave_ready = bus.s_resp[0];

  always_comb begin
    sel_valid = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (sel == SEL_W'(i)) sel_valid = req_valid[i];
    end
  end

  // Scan rr_ptr, rr_ptr+1, ... modulo N_MASTERS; the first requester wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < N_MASTERS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_MASTERS) idx = idx - N_MASTERS;
      for (int i = 0; i < N_MASTERS; i++) begin
        if (!found && (idx == i) && req_valid[i]) begin
          found = 1'b1;
          pick  = SEL_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      sel    <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      sel    <= sel_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = BUSY;
          sel_nxt   = pick;
        end
      end
      BUSY: begin
        // Completion takes precedence over an abort in the same cycle.
        if (slave_ready) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = (sel == SEL_W'(N_MASTERS - 1)) ? '0 : sel + 1'b1;
        end else if (!sel_valid) begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    bus.s_req  = '0;
    bus.m_resp = '0;
    if (state == BUSY) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (sel == SEL_W'(i)) begin
          bus.s_req                        = bus.m_req[i*REQ_W +: REQ_W];
          bus.m_resp[i*RESP_W +: RESP_W]   = bus.s_resp;
        end
      end
    end
  end

  assign dbg_state  = (state == BUSY);
  assign dbg_sel    = sel;
  assign dbg_rr_ptr = rr_ptr;

endmodule

// File: doc/merge.md
# merge

Round-robin N-to-1 bus merger for the native valid/ready memory interface: arbitrates between `N_MASTERS` requesting masters and forwards exactly one outstanding transaction at a time to a single slave port. It is the counterpart of `split`. Typical uses are two CPU buses (instruction and data) sharing one memory, or several DMA engines sharing one peripheral. Grant is held from the cycle the request is forwarded until the slave returns `ready`, and priority rotates after every completed transaction.

## Interface
- `DATA_W`, 32, data width in bits.
- `ADDR_W`, 32, address width in bits.
- `N_MASTERS`, 2, number of masters; must be ≥ 2 and need not be a power of two.
- Request word, `REQ_W` = 1+`ADDR_W`+`DATA_W`+`DATA_W`/8, packed msb→lsb as {valid, addr, wdata, wstrb}.
- Response word, `RESP_W` = `DATA_W`+1, packed msb→lsb as {rdata, ready}.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `m_req`  in  `N_MASTERS`*`REQ_W`  master requests; master i occupies slice [i*`REQ_W` +: `REQ_W`].
- `m_resp`  out  `N_MASTERS`*`RESP_W`  master responses; same slicing rule.
- `s_req`  out  `REQ_W`  request to the slave.
- `s_resp`  in  `RESP_W`  response from the slave.

## Operation
- State registers:
  - `state` ∈ {IDLE, BUSY}.
  - `sel` holds the granted master index, $clog2(`N_MASTERS`) bits.
  - `rr_ptr` is the highest-priority index, same width.
- Reset (`rst_n`=0 at a clock edge): state=IDLE, sel=0, rr_ptr=0. Reset overrides every other event, including a transaction in flight; that transaction is abandoned and gets no response.
- IDLE:
  - `s_req` = 0 and `m_resp` = 0.
  - If any master has valid=1, grant the first requesting index found scanning rr_ptr, rr_ptr+1, … `N_MASTERS`-1, 0, … (modulo `N_MASTERS`).
  - Load sel with that index and go to BUSY.
  - If no master has valid=1, stay in IDLE.
  - `s_resp` is ignored in IDLE.
- BUSY:
  - `s_req` = m_req[sel], the full word passed through combinationally.
  - m_resp[sel] = `s_resp`; every other m_resp slice = 0.
  - Non-selected masters keep waiting; their valid is not forwarded.
- Completion: in BUSY with `s_resp`.ready=1, go to IDLE, and rr_ptr ← sel+1, wrapping from `N_MASTERS`-1 to 0.
- Abort: in BUSY with m_req[sel].valid=0 and ready=0, go to IDLE with rr_ptr unchanged.
- Only one transaction is outstanding at any time.
- A master must hold valid, addr, wdata and wstrb stable until it sees ready.
- Outputs are combinational functions of state, sel and the inputs. There is no data-path register.

## Timing
- A request sampled in IDLE at edge k appears on `s_req` in the cycle after edge k.
- `ready` is seen by the granted master in the same cycle the slave asserts it, with zero added latency.
- After completion there is one IDLE bubble cycle. Back-to-back throughput is therefore at most one transaction per 2 cycles for a 1-cycle-ready slave.
- Fairness: with all masters continuously requesting, each master is granted once every `N_MASTERS` transactions.
- Simultaneous new requests and completion: completion is handled first. New requests are arbitrated in the following IDLE cycle using the updated rr_ptr.
- `ready` arriving in the first BUSY cycle is valid and completes the transaction.

## Test plan
- Reset:
  - Stimulus: hold `rst_n`=0 for 3 cycles while all masters drive valid=1.
  - Required: `s_req`=0 and `m_resp`=0 throughout. The first grant after release is master 0, and `s_req` is valid in the cycle after the first IDLE edge.
- Single write:
  - Stimulus: master 1 writes addr=0x10, wdata=0xDEADBEEF, wstrb=0xF; the slave asserts ready 3 cycles after `s_req`.valid rises.
  - Required: `s_req` equals master 1's word for exactly 4 cycles. m_resp[1].ready pulses once and m_resp[0] stays 0.
- Round-robin, `N_MASTERS`=3:
  - Stimulus: all masters request continuously with a 1-cycle-ready slave.
  - Required: grant order 0,1,2,0,1,2, with each transaction occupying 2 cycles.
- Contention:
  - Stimulus: master 0 is in BUSY with ready delayed 5 cycles when master 1 raises valid.
  - Required: master 1 is not forwarded until the cycle after master 0's ready, and rr_ptr=1 at that point.
- Reset mid-transaction:
  - Stimulus: assert `rst_n`=0 during BUSY for master 1.
  - Required: IDLE on the next cycle, no ready delivered to master 1, and rr_ptr=0.
- Abort:
  - Stimulus: master 0 drops valid in BUSY before ready.
  - Required: `s_req`.valid=0 the next cycle. A pending master 1 is granted one cycle later, and rr_ptr remains 0.
